adc_acq_ctrl_async: RTL
=======================

# adc_acq_ctrl_async

Sequencing controller for asynchronous-mode fills. It sits directly upstream of the ADC data mux and drives the mux's select and checksum strobes: one waveform header plus N data bursts per trigger, then a fill header and a closing checksum. It also supplies the mux's fill and waveform bookkeeping values, and produces the DDR3 write-FIFO write strobe and burst address, aligned to the mux's registered output.

## Interface
- `MEM_BURSTS`, default 23'd4194303: highest burst count a fill may occupy in DDR3. Counts headers, data and checksum.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `fill_start` in 1: pulse that opens a fill. Accepted only in IDLE.
- `fill_end` in 1: pulse that closes the fill window.
- `trigger` in 1: asynchronous-waveform trigger pulse, already synchronous to `clk`.
- `fifo_afull` in 1: DDR3 write FIFO almost full.
- `async_num_bursts` in 14: data bursts per waveform (N). Latched in INIT.
- `select_fill_hdr`, `select_waveform_hdr`, `select_dat`, `select_checksum` out 1 each: mux selects. At most one is high in any cycle.
- `checksum_init`, `checksum_update` out 1 each: mux checksum control.
- `num_fill_bursts` out 23: total bursts in the fill so far.
- `waveform_start_adr` out 23: burst address of the current waveform header.
- `current_waveform_num` out 23: waveform index.
- `fill_num` out 24: fill number.
- `fifo_wr` out 1: write strobe. It is the OR of all four selects, delayed 1 cycle.
- `fifo_adr` out 23: burst address for `fifo_wr`. Delayed 1 cycle, the same as `fifo_wr`.
- `busy` out 1: high from INIT through CHKSUM.
- `done` out 1: 1-cycle pulse in the cycle after CHKSUM.
- `trig_missed` out 1: sticky. Cleared in INIT.
- `mem_full` out 1: sticky. Cleared in INIT.

## Operation
States: IDLE → INIT → ARMED → {WFM_HDR → DATA → ARMED}* → FILL_HDR → CHKSUM → IDLE.

- **IDLE**
  - All strobes are 0.
  - `fill_start` → INIT. `fill_start` in any other state is ignored.
- **INIT** (1 cycle)
  - `checksum_init`=1.
  - Latch N.
  - Clear `current_waveform_num` and both sticky flags.
  - Set next address `nadr`=1. Address 0 is reserved for the fill header.
- **ARMED**
  - `fill_end` → FILL_HDR. If `fill_end` and `trigger` arrive in the same cycle, `fill_end` wins.
  - Otherwise, on `trigger`:
    - If `fifo_afull`=1, set `trig_missed` and stay in ARMED.
    - Else, if `nadr`+1+N+1 > `MEM_BURSTS`, set `mem_full` and stay in ARMED.
    - Else → WFM_HDR with `waveform_start_adr`=`nadr`.
- **WFM_HDR** (1 cycle)
  - `select_waveform_hdr`=1.
  - If N=0, return to ARMED; otherwise → DATA.
- **DATA** (N cycles)
  - `select_dat`=1 and `checksum_update`=1 every cycle.
  - `fifo_afull` does not stall DATA, because the ADC stream cannot pause.
  - On the last data cycle, `current_waveform_num`+=1 and `nadr`+=1+N, then → ARMED. When N=0, this increment happens in WFM_HDR instead.
- **Triggers outside ARMED**: ignored, and `trig_missed` is set.
- **`fill_end` during WFM_HDR or DATA**: held pending. The waveform completes, then the FSM goes straight to FILL_HDR.
- **FILL_HDR** (1 cycle)
  - `select_fill_hdr`=1, with `fifo_adr` target 0.
  - `current_waveform_num` = W, the final waveform count.
- **CHKSUM** (1 cycle)
  - `select_checksum`=1, with target address `nadr`.
  - The fill header's checksum update has already landed by this cycle.
- **After CHKSUM**: `done`=1, `fill_num`+=1 (wraps at 2^24), → IDLE.
- **Burst count**: `num_fill_bursts` = `nadr`+1. After W waveforms this equals W·(1+N)+2.
- **Reset**, including mid-fill:
  - State goes to IDLE.
  - Every output is 0, including `fill_num`, `fifo_wr` and the flags.
  - No partial fill header or checksum is emitted.

## Timing
- `fill_start` at cycle 0 → INIT at cycle 1 → ARMED at cycle 2.
- `trigger` sampled at cycle t in ARMED:
  - WFM_HDR at t+1.
  - DATA at t+2 … t+1+N.
  - ARMED again at t+2+N, so the next trigger can be accepted at cycle t+2+N.
- `fifo_wr` and `fifo_adr` lag the selects by exactly 1 cycle.
- Within a waveform, data addresses are `waveform_start_adr`+1 … `waveform_start_adr`+N.
- `fill_end` sampled at cycle e in ARMED:
  - FILL_HDR at e+1.
  - CHKSUM at e+2.
  - `done` at e+3.
  - Last `fifo_wr` (the checksum) at e+3.
- `waveform_start_adr` and `current_waveform_num` are stable from WFM_HDR through the end of DATA.

## Test plan
- **Basic fill.** N=2; `fill_start`; two triggers spaced 10 cycles apart; `fill_end`.
  - Expected writes: addresses 1 (WH0), 2, 3, 4 (WH1), 5, 6, 0 (FH), 7 (CK).
  - Expected values: `num_fill_bursts`=8; `current_waveform_num`=2 at FILL_HDR; `fill_num` 0→1 after `done`.
- **Back-to-back and overlapping triggers.** N=4; `trigger` at t and again at t+6; a third `trigger` at t+3.
  - The third trigger is ignored and `trig_missed`=1.
  - The second waveform header is at address 6.
- **Simultaneous and pending `fill_end`.** `trigger` and `fill_end` in the same ARMED cycle → no waveform, FILL_HDR next, `num_fill_bursts`=2.
  - Separately, `fill_end` asserted mid-DATA → the waveform completes, then FILL_HDR.
- **Memory limit.** `MEM_BURSTS`=10, N=3.
  - Waveforms at addresses 1 and 5 are accepted.
  - The third trigger is refused (9+5>10) and `mem_full`=1.
  - The checksum is written at address 9.
- **Backpressure, N=0, reset.**
  - `fifo_afull`=1 in ARMED → the trigger is dropped with `trig_missed`=1.
  - N=0 → waveform header only, with `nadr` advancing by 1.
  - `reset` during DATA → all outputs 0 on the next cycle; a new `fill_start` runs cleanly with `fill_num`=0.

Source files
------------

// File: rtl/adc_acq_ctrl_async.sv
// Asynchronous-mode fill sequencer for the ADC data mux: emits waveform headers, data
// bursts, fill header and checksum, plus the DDR3 write strobe/address one cycle later.
module adc_acq_ctrl_async #(
   parameter logic [22:0] MEM_BURSTS = 23'd4194303
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fill_start,
   input  logic        fill_end,
   input  logic        trigger,
   input  logic        fifo_afull,
   input  logic [13:0] async_num_bursts,
   output logic        select_fill_hdr,
   output logic        select_waveform_hdr,
   output logic        select_dat,
   output logic        select_checksum,
   output logic        checksum_init,
   output logic        checksum_update,
   output logic [22:0] num_fill_bursts,
   output logic [22:0] waveform_start_adr,
   output logic [22:0] current_waveform_num,
   output logic [23:0] fill_num,
   output logic        fifo_wr,
   output logic [22:0] fifo_adr,
   output logic        busy,
   output logic        done,
   output logic        trig_missed,
   output logic        mem_full
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_ARMED,
      S_WFM_HDR,
      S_DATA,
      S_FILL_HDR,
      S_CHKSUM
   } state_t;

   state_t      state_q, state_d;
   logic [13:0] n_q, n_d;
   logic [13:0] cnt_q, cnt_d;
   logic [22:0] nadr_q, nadr_d;
   logic [22:0] wsa_q, wsa_d;
   logic [22:0] wnum_q, wnum_d;
   logic [22:0] nfb_q, nfb_d;
   logic [23:0] fill_num_q, fill_num_d;
   logic        trig_missed_q, trig_missed_d;
   logic        mem_full_q, mem_full_d;
   logic        fe_pend_q, fe_pend_d;
   logic        fifo_wr_q, fifo_wr_d;
   logic [22:0] fifo_adr_q, fifo_adr_d;
   logic        done_q, done_d;

   logic        sel_fh, sel_wh, sel_dat, sel_ck;
   logic        cks_init, cks_upd;
   logic [22:0] wr_adr;
   logic [24:0] need_bursts;
   logic        fits;
   logic        last_dat;
   logic        wfm_done;

   // A waveform needs its header, N data bursts, and room left for the closing checksum.
   assign need_bursts = {2'b00, nadr_q} + {11'd0, n_q} + 25'd2;
   assign fits        = (need_bursts <= {2'b00, MEM_BURSTS});
   assign last_dat    = (cnt_q == (n_q - 14'd1));
   assign wfm_done    = ((state_q == S_WFM_HDR) && (n_q == 14'd0)) ||
                        ((state_q == S_DATA) && last_dat);

   always_comb begin
      state_d       = state_q;
      n_d           = n_q;
      cnt_d         = cnt_q;
      nadr_d        = nadr_q;
      wsa_d         = wsa_q;
      wnum_d        = wnum_q;
      fill_num_d    = fill_num_q;
      trig_missed_d = trig_missed_q;
      mem_full_d    = mem_full_q;
      fe_pend_d     = fe_pend_q;
      sel_fh        = 1'b0;
      sel_wh        = 1'b0;
      sel_dat       = 1'b0;
      sel_ck        = 1'b0;
      cks_init      = 1'b0;
      cks_upd       = 1'b0;
      wr_adr        = '0;

      case (state_q)
         S_IDLE: begin
            if (fill_start) state_d = S_INIT;
         end
         S_INIT: begin
            cks_init      = 1'b1;
            n_d           = async_num_bursts;
            wnum_d        = '0;
            trig_missed_d = 1'b0;
            mem_full_d    = 1'b0;
            fe_pend_d     = 1'b0;
            nadr_d        = 23'd1;
            state_d       = S_ARMED;
         end
         S_ARMED: begin
            if (fill_end) begin
               state_d = S_FILL_HDR;
            end else if (trigger) begin
               if (fifo_afull) begin
                  trig_missed_d = 1'b1;
               end else if (!fits) begin
                  mem_full_d = 1'b1;
               end else begin
                  wsa_d   = nadr_q;
                  state_d = S_WFM_HDR;
               end
            end
         end
         S_WFM_HDR: begin
            sel_wh = 1'b1;
            wr_adr = wsa_q;
            cnt_d  = '0;
            if (fill_end) fe_pend_d = 1'b1;
            if (n_q != 14'd0) state_d = S_DATA;
         end
         S_DATA: begin
            sel_dat = 1'b1;
            cks_upd = 1'b1;
            wr_adr  = wsa_q + 23'd1 + {9'd0, cnt_q};
            cnt_d   = cnt_q + 14'd1;
            if (fill_end) fe_pend_d = 1'b1;
         end
         S_FILL_HDR: begin
            sel_fh  = 1'b1;
            cks_upd = 1'b1;
            wr_adr  = '0;
            state_d = S_CHKSUM;
         end
         S_CHKSUM: begin
            sel_ck     = 1'b1;
            wr_adr     = nadr_q;
            fill_num_d = fill_num_q + 24'd1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // End of a waveform: advance bookkeeping and honour any fill_end seen meanwhile.
      if (wfm_done) begin
         wnum_d    = wnum_q + 23'd1;
         nadr_d    = nadr_q + 23'd1 + {9'd0, n_q};
         state_d   = (fe_pend_q || fill_end) ? S_FILL_HDR : S_ARMED;
         fe_pend_d = 1'b0;
      end

      if (trigger && (state_q != S_ARMED)) trig_missed_d = 1'b1;
   end

   assign fifo_wr_d  = sel_fh | sel_wh | sel_dat | sel_ck;
   assign fifo_adr_d = wr_adr;
   assign done_d     = (state_q == S_CHKSUM);
   assign nfb_d      = (state_q == S_IDLE) ? nfb_q : (nadr_d + 23'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         n_q           <= '0;
         cnt_q         <= '0;
         nadr_q        <= '0;
         wsa_q         <= '0;
         wnum_q        <= '0;
         nfb_q         <= '0;
         fill_num_q    <= '0;
         trig_missed_q <= 1'b0;
         mem_full_q    <= 1'b0;
         fe_pend_q     <= 1'b0;
         fifo_wr_q     <= 1'b0;
         fifo_adr_q    <= '0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         n_q           <= n_d;
         cnt_q         <= cnt_d;
         nadr_q        <= nadr_d;
         wsa_q         <= wsa_d;
         wnum_q        <= wnum_d;
         nfb_q         <= nfb_d;
         fill_num_q    <= fill_num_d;
         trig_missed_q <= trig_missed_d;
         mem_full_q    <= mem_full_d;
         fe_pend_q     <= fe_pend_d;
         fifo_wr_q     <= fifo_wr_d;
         fifo_adr_q    <= fifo_adr_d;
         done_q        <= done_d;
      end
   end

   assign select_fill_hdr      = sel_fh;
   assign select_waveform_hdr  = sel_wh;
   assign select_dat           = sel_dat;
   assign select_checksum      = sel_ck;
   assign checksum_init        = cks_init;
   assign checksum_update      = cks_upd;
   assign num_fill_bursts      = nfb_q;
   assign waveform_start_adr   = wsa_q;
   assign current_waveform_num = wnum_q;
   assign fill_num             = fill_num_q;
   assign fifo_wr              = fifo_wr_q;
   assign fifo_adr             = fifo_adr_q;
   assign busy                 = (state_q != S_IDLE);
   assign done                 = done_q;
   assign trig_missed          = trig_missed_q;
   assign mem_full             = mem_full_q;

endmodule
